// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 serial receiver with a small receive FIFO and sticky error flags.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 and adds the parity_err output.
module uart_rx_monitor #(
    parameter int unsigned CLKS_PER_BIT = 1736,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overrun,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    input  logic                          clr_status
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_e;

    // synchronizer and edge detect
    logic rxd_meta_q, rxd_meta_d;
    logic rxd_s_q, rxd_s_d;
    logic rxd_prev_q, rxd_prev_d;
    logic fall_c;

    // receiver
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_q, push_d;
    logic             busy_q, busy_d;
    logic             frame_set_c;
    logic             parity_set_c;

    // fifo
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             do_push_c, do_pop_c, full_c, ovr_set_c;

    // sticky status
    logic frame_err_q, frame_err_d;
    logic overrun_q, overrun_d;
    logic parity_err_q, parity_err_d;

    // Synchronizer chain; the previous synchronized sample feeds the falling-edge detector.
    always_comb begin
        rxd_meta_d = rxd;
        rxd_s_d    = rxd_meta_q;
        rxd_prev_d = rxd_s_q;
        fall_c     = ~rxd_s_q & rxd_prev_q;
    end

    // Receiver next-state: bit timing, sampling and push request.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        push_d       = 1'b0;
        frame_set_c  = 1'b0;
        parity_set_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall_c) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_CNT) begin
                    if (rxd_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = ST_DATA;
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            ST_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rxd_s_q;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = 3'(bit_idx_q + 1'b1);
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d        = '0;
                    parity_set_c = (^shift_q) ^ rxd_s_q;
                    state_d      = ST_STOP;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rxd_s_q) begin
                        push_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_set_c = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            ST_BREAK: begin
                if (rxd_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FIFO: push one cycle after the stop sample, pop on valid & ready, registered head.
    always_comb begin
        full_c    = (level_q == DEPTH_LVL);
        do_pop_c  = rx_valid_q & rx_ready;
        do_push_c = push_q & (~full_c | do_pop_c);
        ovr_set_c = push_q & full_c & ~do_pop_c;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (do_push_c) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
        end
        if (do_pop_c) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        end
        case ({do_push_c, do_pop_c})
            2'b10:   level_d = LVL_W'(level_q + 1'b1);
            2'b01:   level_d = LVL_W'(level_q - 1'b1);
            default: level_d = level_q;
        endcase
        rx_valid_d = (level_d != '0);
        rx_data_d  = rx_valid_d ? mem_d[rd_ptr_d] : rx_data_q;
    end

    // Sticky flags: clear first, a coincident error event wins.
    always_comb begin
        frame_err_d  = (frame_err_q & ~clr_status) | frame_set_c;
        overrun_d    = (overrun_q & ~clr_status) | ovr_set_c;
        parity_err_d = (parity_err_q & ~clr_status) | parity_set_c;
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta_q   <= 1'b1;
            rxd_s_q      <= 1'b1;
            rxd_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            push_q       <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rxd_meta_q   <= rxd_meta_d;
            rxd_s_q      <= rxd_s_d;
            rxd_prev_q   <= rxd_prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            push_q       <= push_d;
            busy_q       <= busy_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign fifo_level = level_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    logic unused_parity_c;
    assign unused_parity_c = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: randomized self-checking bench for uart_rx_monitor (CLKS_PER_BIT=16, FIFO_DEPTH=4).
module tb_uart_rx_monitor;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int HALF  = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;
    // stop sample lands HALF + (NB-1) bit periods after the start edge, plus 3 cycles of
    // synchronizer/edge detect; rx_valid follows the stop sample by 2 cycles
    localparam int LAT = (NB - 1) * CPB + HALF + 5;

    logic       clk;
    logic       reset_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] fifo_level;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       clr_status;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       tx_par;
`endif

    int         total;
    int         bad;
    logic       trace [0:FRAME];
    logic [7:0] got [$];

    uart_rx_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_level (fifo_level),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .clr_status (clr_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // consumer log: a byte is taken whenever valid and ready are both high before the edge
    always @(negedge clk) begin
        if (reset_n && rx_valid && rx_ready) got.push_back(rx_data);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        tick(1);
        clr_status = 1'b0;
    endtask

    // act: 0 none, 1 rx_ready high for cycle act_cyc, 2 clr_status high for cycle act_cyc
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int act, input int act_cyc);
        logic [NB-1:0] bits;
        bits      = '0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]   = tx_par;
`endif
        bits[NB-1] = stop_b;
        for (int c = 0; c < FRAME; c++) begin
            rxd = bits[c / CPB];
            if (act == 1) rx_ready = (c == act_cyc);
            if (act == 2) clr_status = (c == act_cyc);
            @(posedge clk);
            #1;
            trace[c + 1] = rx_valid;
        end
        if (act == 1) rx_ready = 1'b0;
        if (act == 2) clr_status = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget   = 0;
        rx_ready = 1'b1;
        while (rx_valid && budget < 64) begin
            tick(1);
            budget++;
        end
        tick(1);
        rx_ready = 1'b0;
        total++;
        if (rx_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_timeout: rx_valid=%0b required 0", rx_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({rx_valid, rx_data, fifo_level, busy, frame_err, overrun} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %0h required 0", {rx_valid, rx_data, fifo_level, busy, frame_err, overrun});
        end
`ifdef UART_RX_PARITY_EN
        total++;
        if (parity_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_parity_err: got %0b required 0", parity_err);
        end
`endif
        tick(4);
        @(negedge clk);
        reset_n = 1'b1;
        tick(4);
    endtask

    task automatic test_basic();
        got.delete();
        rx_ready = 1'b0;
        send_frame(8'h55, 1'b1, 0, 0);
        total++;
        if (trace[LAT - 1] !== 1'b0 || trace[LAT] !== 1'b1) begin
            bad++;
            $display("FAIL basic_latency: valid before/at=%0b%0b required 01", trace[LAT - 1], trace[LAT]);
        end
        total++;
        if (rx_data !== 8'h55 || fifo_level !== 3'd1) begin
            bad++;
            $display("FAIL basic_head: data=%0h level=%0d required 55 1", rx_data, fifo_level);
        end
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        total++;
        if (fifo_level !== 3'd0 || rx_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_pop: level=%0d valid=%0b required 0 0", fifo_level, rx_valid);
        end
        total++;
        if (got.size() != 1) begin
            bad++;
            $display("FAIL basic_log_size: got %0d required 1", got.size());
        end else if (got[0] !== 8'h55) begin
            bad++;
            $display("FAIL basic_log_data: got %0h required 55", got[0]);
        end
    endtask

    task automatic test_glitch();
        logic saw;
        saw = 1'b0;
        rxd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            saw = saw | busy;
        end
        rxd = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            saw = saw | busy;
        end
        total++;
        if (saw !== 1'b1) begin
            bad++;
            $display("FAIL glitch_busy_pulse: got %0b required 1", saw);
        end
        total++;
        if (busy !== 1'b0 || fifo_level !== 3'd0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL glitch_idle: busy=%0b level=%0d ferr=%0b required 0 0 0", busy, fifo_level, frame_err);
        end
    endtask

    task automatic test_frame_err();
        got.delete();
        send_frame(8'hA5, 1'b0, 0, 0);
        rxd = 1'b0;
        tick(40);
        total++;
        if (frame_err !== 1'b1 || fifo_level !== 3'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL break_state: ferr=%0b level=%0d busy=%0b required 1 0 1", frame_err, fifo_level, busy);
        end
        rxd = 1'b1;
        tick(10);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL break_exit: busy=%0b required 0", busy);
        end
        send_frame(8'h3C, 1'b1, 0, 0);
        tick(2);
        total++;
        if (fifo_level !== 3'd1 || rx_data !== 8'h3C) begin
            bad++;
            $display("FAIL after_break_byte: level=%0d data=%0h required 1 3c", fifo_level, rx_data);
        end
        drain();
        pulse_clr();
        total++;
        if (frame_err !== 1'b0) begin
            bad++;
            $display("FAIL frame_err_clear: got %0b required 0", frame_err);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp [$];
        got.delete();
        rx_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            send_frame(8'(v), 1'b1, 0, 0);
            if (exp.size() < DEPTH) exp.push_back(8'(v));
        end
        tick(2);
        total++;
        if (fifo_level !== 3'(DEPTH) || overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_set: level=%0d ovr=%0b required %0d 1", fifo_level, overrun, DEPTH);
        end
        // clear lands on the same edge as another overflowing push
        send_frame(8'h06, 1'b1, 2, LAT - 1);
        total++;
        if (overrun !== 1'b1 || fifo_level !== 3'(DEPTH)) begin
            bad++;
            $display("FAIL overrun_set_wins: ovr=%0b level=%0d required 1 %0d", overrun, fifo_level, DEPTH);
        end
        pulse_clr();
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clear: got %0b required 0", overrun);
        end
        drain();
        total++;
        if (got.size() != exp.size()) begin
            bad++;
            $display("FAIL overrun_read_count: got %0d required %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                total++;
                if (got[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL overrun_read_%0d: got %0h required %0h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_full_pop();
        got.delete();
        rx_ready = 1'b0;
        for (int v = 1; v <= 4; v++) send_frame(8'(v), 1'b1, 0, 0);
        send_frame(8'h05, 1'b1, 1, LAT - 1);
        tick(2);
        total++;
        if (overrun !== 1'b0 || fifo_level !== 3'(DEPTH)) begin
            bad++;
            $display("FAIL full_pop_push: ovr=%0b level=%0d required 0 %0d", overrun, fifo_level, DEPTH);
        end
        drain();
        total++;
        if (got.size() != 5) begin
            bad++;
            $display("FAIL full_pop_count: got %0d required 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (got[i] !== 8'(i + 1)) begin
                    bad++;
                    $display("FAIL full_pop_read_%0d: got %0h required %0h", i, got[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NB-1:0] bits;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 0, 0);
        bits      = '1;
        bits[0]   = 1'b0;
        for (int c = 0; c < 4 * CPB + HALF; c++) begin
            rxd = bits[c / CPB];
            tick(1);
        end
        reset_n = 1'b0;
        rxd     = 1'b1;
        #1;
        total++;
        if ({rx_valid, rx_data, fifo_level, busy, frame_err, overrun} !== 14'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got %0h required 0", {rx_valid, rx_data, fifo_level, busy, frame_err, overrun});
        end
        tick(3);
        @(negedge clk);
        reset_n = 1'b1;
        tick(3);
        got.delete();
        send_frame(8'h3C, 1'b1, 0, 0);
        tick(2);
        total++;
        if (fifo_level !== 3'd1 || rx_data !== 8'h3C) begin
            bad++;
            $display("FAIL reset_mid_next: level=%0d data=%0h required 1 3c", fifo_level, rx_data);
        end
        drain();
        total++;
        if (got.size() != 1) begin
            bad++;
            $display("FAIL reset_mid_only_byte: count=%0d required 1", got.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [$];
        logic [7:0] d;
        logic       exp_perr;
        int         gap;
        pulse_clr();
        got.delete();
        exp_perr = 1'b0;
        rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d   = 8'($urandom);
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
`ifdef UART_RX_PARITY_EN
            tx_par   = 1'($urandom);
            exp_perr = exp_perr | ((^d) ^ tx_par);
`endif
            exp.push_back(d);
            send_frame(d, 1'b1, 0, 0);
            rx_ready = 1'b1;
            tick(gap);
        end
        tick(10);
        rx_ready = 1'b0;
        total++;
        if (got.size() != exp.size()) begin
            bad++;
            $display("FAIL stream_count: got %0d required %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                total++;
                if (got[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL stream_byte_%0d: got %0h required %0h", i, got[i], exp[i]);
                end
            end
        end
        total++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL stream_flags: ferr=%0b ovr=%0b required 0 0", frame_err, overrun);
        end
`ifdef UART_RX_PARITY_EN
        total++;
        if (parity_err !== exp_perr) begin
            bad++;
            $display("FAIL stream_parity_err: got %0b required %0b", parity_err, exp_perr);
        end
`endif
    endtask

    task automatic test_random_fill();
        logic [7:0] exp [$];
        logic [7:0] d;
        logic       exp_ovr;
        int         n;
        for (int r = 0; r < 3; r++) begin
            pulse_clr();
            got.delete();
            exp.delete();
            exp_ovr  = 1'b0;
            rx_ready = 1'b0;
            n = int'($urandom_range(1, 7));
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
`ifdef UART_RX_PARITY_EN
                tx_par = ^d;
`endif
                send_frame(d, 1'b1, 0, 0);
                if (exp.size() < DEPTH) exp.push_back(d);
                else exp_ovr = 1'b1;
            end
            tick(2);
            total++;
            if (fifo_level !== 3'(exp.size()) || overrun !== exp_ovr) begin
                bad++;
                $display("FAIL fill_%0d_state: level=%0d ovr=%0b required %0d %0b", r, fifo_level, overrun, exp.size(), exp_ovr);
            end
            drain();
            total++;
            if (got.size() != exp.size()) begin
                bad++;
                $display("FAIL fill_%0d_count: got %0d required %0d", r, got.size(), exp.size());
            end else begin
                for (int i = 0; i < exp.size(); i++) begin
                    total++;
                    if (got[i] !== exp[i]) begin
                        bad++;
                        $display("FAIL fill_%0d_byte_%0d: got %0h required %0h", r, i, got[i], exp[i]);
                    end
                end
            end
        end
        pulse_clr();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        pulse_clr();
        rx_ready = 1'b0;
        tx_par   = 1'b1;
        send_frame(8'h07, 1'b1, 0, 0);
        tick(2);
        total++;
        if (parity_err !== ((^8'h07) ^ 1'b1) || fifo_level !== 3'd1) begin
            bad++;
            $display("FAIL parity_one: perr=%0b level=%0d required %0b 1", parity_err, fifo_level, (^8'h07) ^ 1'b1);
        end
        tx_par = 1'b0;
        send_frame(8'h07, 1'b1, 0, 0);
        tick(2);
        total++;
        if (parity_err !== 1'b1 || fifo_level !== 3'd2 || rx_data !== 8'h07) begin
            bad++;
            $display("FAIL parity_zero: perr=%0b level=%0d data=%0h required 1 2 07", parity_err, fifo_level, rx_data);
        end
        drain();
        pulse_clr();
        total++;
        if (parity_err !== 1'b0) begin
            bad++;
            $display("FAIL parity_clear: got %0b required 0", parity_err);
        end
    endtask
`endif

    initial begin
        total      = 0;
        bad        = 0;
        rxd        = 1'b1;
        rx_ready   = 1'b0;
        clr_status = 1'b0;
        reset_n    = 1'b1;
`ifdef UART_RX_PARITY_EN
        tx_par     = 1'b0;
`endif
        test_reset();
`ifdef UART_RX_PARITY_EN
        tx_par = ^8'h55;
`endif
        test_basic();
        test_glitch();
`ifdef UART_RX_PARITY_EN
        tx_par = ^8'hA5;
`endif
        test_frame_err();
        test_overrun();
        test_full_pop();
        test_reset_mid();
        test_back_to_back();
        test_random_fill();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
